cmo_dc_sequencer: RTL and testbench

- Sits directly downstream of the CMO functional unit, on its D-cache request/response channel (cmo_req_t / cmo_resp_t).
- Turns each accepted CMO into zero or more single-line maintenance operations on the D-cache controller's line-op port.
  - Address-based ops become one aligned-line op.
  - *_ALL ops are walked over every set and way.
  - Prefetch hints complete without touching the cache.
- Returns exactly one ack per accepted CMO, tagged with its trans_id.

---
 rtl/ariane_pkg.sv | 31 +++
 rtl/riscv.sv | 5 +
 rtl/cmo_dc_sequencer.sv | 134 +++++++++++++
 tb/tb_cmo_dc_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// CMO opcodes and the CMO unit's D-cache request/response bundles.
package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        CMO_NONE,
        CMO_CLEAN,
        CMO_FLUSH,
        CMO_INVAL,
        CMO_ZERO,
        CMO_PREFETCH_I,
        CMO_PREFETCH_R,
        CMO_PREFETCH_W,
        CMO_CLEAN_ALL,
        CMO_FLUSH_ALL,
        CMO_INVAL_ALL
    } cmo_t;

    typedef struct packed {
        logic                     req;
        logic [TRANS_ID_BITS-1:0] trans_id;
        riscv::xlen_t             address;
        cmo_t                     cmo_op;
    } cmo_req_t;

    typedef struct packed {
        logic                     req_ready;
        logic                     ack;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } cmo_resp_t;
endpackage

// File: rtl/riscv.sv
// Base ISA types shared by the core and its memory-side blocks.
package riscv;
    localparam int unsigned XLEN = 64;
    typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/cmo_dc_sequencer.sv
// Expands accepted CMOs into single-line D-cache maintenance ops,
// walking every set/way for *_ALL ops, and acks each CMO once.
module cmo_dc_sequencer
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned NUM_WAYS   = 8,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned SET_W      = $clog2(NUM_SETS),
    parameter int unsigned WAY_W      = $clog2(NUM_WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  cmo_req_t            cmo_req_i,
    output cmo_resp_t           cmo_resp_o,
    output logic                line_req_o,
    input  logic                line_gnt_i,
    input  logic                line_done_i,
    output cmo_t                line_op_o,
    output logic                line_by_index_o,
    output riscv::xlen_t        line_addr_o,
    output logic [SET_W-1:0]    line_set_o,
    output logic [WAY_W-1:0]    line_way_o
);

    typedef enum logic [2:0] {
        IDLE,
        LINE_REQ,
        LINE_WAIT,
        ALL_REQ,
        ALL_WAIT,
        ACK
    } state_t;

    localparam riscv::xlen_t LINE_MASK = ~riscv::xlen_t'(LINE_BYTES - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [TRANS_ID_BITS-1:0] r_tid;
    cmo_t                     r_op;
    riscv::xlen_t             r_addr;
    logic [SET_W-1:0]         r_set;
    logic [WAY_W-1:0]         r_way;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_step;

    assign w_ready  = (r_state == IDLE);
    assign w_accept = cmo_req_i.req & w_ready;
    assign w_last   = (r_set == SET_W'(NUM_SETS - 1)) &&
                      (r_way == WAY_W'(NUM_WAYS - 1));
    assign w_step   = (r_state == ALL_WAIT) & line_done_i & ~w_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    unique case (cmo_req_i.cmo_op)
                        CMO_CLEAN, CMO_FLUSH,
                        CMO_INVAL, CMO_ZERO:     w_next = LINE_REQ;
                        CMO_CLEAN_ALL, CMO_FLUSH_ALL,
                        CMO_INVAL_ALL:           w_next = ALL_REQ;
                        default:                 w_next = ACK;
                    endcase
                end
            end
            LINE_REQ:  if (line_gnt_i)  w_next = LINE_WAIT;
            LINE_WAIT: if (line_done_i) w_next = ACK;
            ALL_REQ:   if (line_gnt_i)  w_next = ALL_WAIT;
            ALL_WAIT:  if (line_done_i) w_next = w_last ? ACK : ALL_REQ;
            ACK:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Captured request plus the set/way walk counters (way innermost).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tid  <= '0;
            r_op   <= CMO_NONE;
            r_addr <= '0;
            r_set  <= '0;
            r_way  <= '0;
        end else if (w_accept) begin
            r_tid  <= cmo_req_i.trans_id;
            r_op   <= cmo_req_i.cmo_op;
            r_addr <= cmo_req_i.address & LINE_MASK;
            r_set  <= '0;
            r_way  <= '0;
        end else if (w_step) begin
            if (r_way == WAY_W'(NUM_WAYS - 1)) begin
                r_way <= '0;
                r_set <= r_set + SET_W'(1);
            end else begin
                r_way <= r_way + WAY_W'(1);
            end
        end
    end

    always_comb begin
        line_op_o = r_op;
        unique case (r_op)
            CMO_CLEAN_ALL: line_op_o = CMO_CLEAN;
            CMO_FLUSH_ALL: line_op_o = CMO_FLUSH;
            CMO_INVAL_ALL: line_op_o = CMO_INVAL;
            default:       line_op_o = r_op;
        endcase
    end

    assign line_req_o      = (r_state == LINE_REQ) || (r_state == ALL_REQ);
    assign line_by_index_o = (r_state == ALL_REQ)  || (r_state == ALL_WAIT);
    assign line_addr_o     = r_addr;
    assign line_set_o      = r_set;
    assign line_way_o      = r_way;

    always_comb begin
        cmo_resp_o           = '0;
        cmo_resp_o.req_ready = w_ready;
        cmo_resp_o.ack       = (r_state == ACK);
        cmo_resp_o.trans_id  = r_tid;
    end

endmodule

// File: tb/tb_cmo_dc_sequencer.sv
// Directed bench for cmo_dc_sequencer on a 4-set, 2-way geometry.
module tb_cmo_dc_sequencer;
    import ariane_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned NW = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    cmo_req_t     cmo_req_i;
    cmo_resp_t    cmo_resp_o;
    logic         line_req_o;
    logic         line_gnt_i = 1'b0;
    logic         line_done_i = 1'b0;
    cmo_t         line_op_o;
    logic         line_by_index_o;
    riscv::xlen_t line_addr_o;
    logic [1:0]   line_set_o;
    logic [0:0]   line_way_o;

    int checks = 0;
    int failures = 0;

    cmo_dc_sequencer #(
        .NUM_SETS   (NS),
        .NUM_WAYS   (NW),
        .LINE_BYTES (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cmo_req_i       (cmo_req_i),
        .cmo_resp_o      (cmo_resp_o),
        .line_req_o      (line_req_o),
        .line_gnt_i      (line_gnt_i),
        .line_done_i     (line_done_i),
        .line_op_o       (line_op_o),
        .line_by_index_o (line_by_index_o),
        .line_addr_o     (line_addr_o),
        .line_set_o      (line_set_o),
        .line_way_o      (line_way_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input cmo_t op,
                         input logic [2:0] tid, input riscv::xlen_t a);
        cmo_req_i.req      = req;
        cmo_req_i.cmo_op   = op;
        cmo_req_i.trans_id = tid;
        cmo_req_i.address  = a;
    endtask

    task automatic test_reset();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        rst_ni = 1'b0;
        tick();
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1 || line_req_o !== 1'b0 ||
            cmo_resp_o.ack !== 1'b0 || cmo_resp_o.trans_id !== 3'd0) begin
            failures++;
            $display("FAIL reset: ready=%b lreq=%b ack=%b tid=%0d want 1 0 0 0",
                     cmo_resp_o.req_ready, line_req_o, cmo_resp_o.ack,
                     cmo_resp_o.trans_id);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, CMO_FLUSH, 3'd5, 64'h8000_1237);
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (line_req_o !== 1'b1 || line_op_o !== CMO_FLUSH ||
                line_by_index_o !== 1'b0 ||
                line_addr_o !== 64'h8000_1230) begin
                failures++;
                $display("FAIL flush_req c%0d: req=%b op=%0d idx=%b addr=%h want 1 %0d 0 80001230",
                         c, line_req_o, line_op_o, line_by_index_o,
                         line_addr_o, CMO_FLUSH);
            end
            if (c == 1) line_gnt_i = 1'b1;
            tick();
        end
        line_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (line_req_o !== 1'b0 || cmo_resp_o.ack !== 1'b0) begin
                failures++;
                $display("FAIL flush_wait c%0d: req=%b ack=%b want 0 0",
                         c, line_req_o, cmo_resp_o.ack);
            end
            if (c == 2) line_done_i = 1'b1;
            tick();
        end
        line_done_i = 1'b0;
        checks++;
        if (cmo_resp_o.ack !== 1'b1 || cmo_resp_o.trans_id !== 3'd5) begin
            failures++;
            $display("FAIL flush_ack: ack=%b tid=%0d want 1 5",
                     cmo_resp_o.ack, cmo_resp_o.trans_id);
        end
        tick();
        checks++;
        if (cmo_resp_o.ack !== 1'b0 || cmo_resp_o.req_ready !== 1'b1 ||
            cmo_resp_o.trans_id !== 3'd5) begin
            failures++;
            $display("FAIL flush_idle: ack=%b ready=%b tid=%0d want 0 1 5",
                     cmo_resp_o.ack, cmo_resp_o.req_ready,
                     cmo_resp_o.trans_id);
        end
    endtask

    task automatic test_prefetch();
        drive(1'b1, CMO_PREFETCH_R, 3'd3, 64'h1000);
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        checks++;
        if (cmo_resp_o.ack !== 1'b1 || cmo_resp_o.trans_id !== 3'd3 ||
            line_req_o !== 1'b0 || cmo_resp_o.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL pf_ack: ack=%b tid=%0d lreq=%b ready=%b want 1 3 0 0",
                     cmo_resp_o.ack, cmo_resp_o.trans_id, line_req_o,
                     cmo_resp_o.req_ready);
        end
        tick();
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1 || cmo_resp_o.ack !== 1'b0 ||
            line_req_o !== 1'b0) begin
            failures++;
            $display("FAIL pf_idle: ready=%b ack=%b lreq=%b want 1 0 0",
                     cmo_resp_o.req_ready, cmo_resp_o.ack, line_req_o);
        end
    endtask

    task automatic test_inval_all();
        int errs;
        errs = 0;
        line_gnt_i  = 1'b1;
        line_done_i = 1'b1;
        drive(1'b1, CMO_INVAL_ALL, 3'd6, '0);
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        for (int i = 0; i < NS * NW; i++) begin
            checks++;
            if (line_req_o !== 1'b1 || line_op_o !== CMO_INVAL ||
                line_by_index_o !== 1'b1 ||
                line_set_o !== 2'(i / NW) || line_way_o !== 1'(i % NW)) begin
                failures++;
                $display("FAIL all_op%0d: req=%b op=%0d idx=%b s=%0d w=%0d want 1 %0d 1 %0d %0d",
                         i, line_req_o, line_op_o, line_by_index_o,
                         line_set_o, line_way_o, CMO_INVAL, i / NW, i % NW);
            end
            tick();
            if (line_req_o !== 1'b0 || cmo_resp_o.ack !== 1'b0) errs++;
            tick();
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL all_wait: bad wait cycles=%0d want 0", errs);
        end
        checks++;
        if (cmo_resp_o.ack !== 1'b1 || cmo_resp_o.trans_id !== 3'd6) begin
            failures++;
            $display("FAIL all_ack: ack=%b tid=%0d want 1 6",
                     cmo_resp_o.ack, cmo_resp_o.trans_id);
        end
        tick();
        line_gnt_i  = 1'b0;
        line_done_i = 1'b0;
        checks++;
        if (cmo_resp_o.ack !== 1'b0 || cmo_resp_o.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL all_idle: ack=%b ready=%b want 0 1",
                     cmo_resp_o.ack, cmo_resp_o.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        line_done_i = 1'b1;
        tick();
        line_done_i = 1'b0;
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1 || cmo_resp_o.ack !== 1'b0 ||
            line_req_o !== 1'b0) begin
            failures++;
            $display("FAIL spurious_done: ready=%b ack=%b lreq=%b want 1 0 0",
                     cmo_resp_o.req_ready, cmo_resp_o.ack, line_req_o);
        end
        drive(1'b1, CMO_FLUSH, 3'd1, 64'h40);
        tick();
        drive(1'b1, CMO_CLEAN, 3'd2, 64'h2_005F);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (cmo_resp_o.req_ready !== 1'b0 || line_op_o !== CMO_FLUSH ||
                line_addr_o !== 64'h40 || line_req_o !== 1'b1) begin
                failures++;
                $display("FAIL held_stall c%0d: ready=%b op=%0d addr=%h want 0 %0d 40",
                         c, cmo_resp_o.req_ready, line_op_o, line_addr_o,
                         CMO_FLUSH);
            end
            tick();
        end
        line_gnt_i = 1'b1;
        tick();
        line_gnt_i  = 1'b0;
        line_done_i = 1'b1;
        tick();
        line_done_i = 1'b0;
        checks++;
        if (cmo_resp_o.ack !== 1'b1 || cmo_resp_o.trans_id !== 3'd1) begin
            failures++;
            $display("FAIL held_ack1: ack=%b tid=%0d want 1 1",
                     cmo_resp_o.ack, cmo_resp_o.trans_id);
        end
        tick();
        checks++;
        if (cmo_resp_o.req_ready !== 1'b1 || line_req_o !== 1'b0) begin
            failures++;
            $display("FAIL held_idle: ready=%b lreq=%b want 1 0",
                     cmo_resp_o.req_ready, line_req_o);
        end
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        checks++;
        if (line_req_o !== 1'b1 || line_op_o !== CMO_CLEAN ||
            line_addr_o !== 64'h2_0050) begin
            failures++;
            $display("FAIL held_second: lreq=%b op=%0d addr=%h want 1 %0d 20050",
                     line_req_o, line_op_o, line_addr_o, CMO_CLEAN);
        end
        line_gnt_i = 1'b1;
        tick();
        line_gnt_i  = 1'b0;
        line_done_i = 1'b1;
        tick();
        line_done_i = 1'b0;
        checks++;
        if (cmo_resp_o.ack !== 1'b1 || cmo_resp_o.trans_id !== 3'd2) begin
            failures++;
            $display("FAIL held_ack2: ack=%b tid=%0d want 1 2",
                     cmo_resp_o.ack, cmo_resp_o.trans_id);
        end
        tick();
    endtask

    task automatic test_reset_mid_all();
        int acks;
        acks = 0;
        line_gnt_i  = 1'b1;
        line_done_i = 1'b1;
        drive(1'b1, CMO_CLEAN_ALL, 3'd4, '0);
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
        end
        checks++;
        if (line_set_o !== 2'd2 || line_way_o !== 1'd0 ||
            line_req_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_pos: s=%0d w=%0d lreq=%b want 2 0 1",
                     line_set_o, line_way_o, line_req_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (line_req_o !== 1'b0 || cmo_resp_o.req_ready !== 1'b1 ||
            cmo_resp_o.ack !== 1'b0 || line_set_o !== 2'd0) begin
            failures++;
            $display("FAIL mid_rst: lreq=%b ready=%b ack=%b s=%0d want 0 1 0 0",
                     line_req_o, cmo_resp_o.req_ready, cmo_resp_o.ack,
                     line_set_o);
        end
        tick();
        rst_ni = 1'b1;
        line_gnt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (cmo_resp_o.ack !== 1'b0 || line_req_o !== 1'b0) acks++;
            tick();
        end
        line_done_i = 1'b0;
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL mid_noack: bad cycles=%0d want 0", acks);
        end
        drive(1'b1, CMO_CLEAN_ALL, 3'd7, '0);
        tick();
        drive(1'b0, CMO_NONE, 3'd0, '0);
        checks++;
        if (line_req_o !== 1'b1 || line_op_o !== CMO_CLEAN ||
            line_by_index_o !== 1'b1 || line_set_o !== 2'd0 ||
            line_way_o !== 1'd0) begin
            failures++;
            $display("FAIL mid_restart: lreq=%b op=%0d idx=%b s=%0d w=%0d want 1 %0d 1 0 0",
                     line_req_o, line_op_o, line_by_index_o, line_set_o,
                     line_way_o, CMO_CLEAN);
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_flush();
        test_prefetch();
        test_inval_all();
        test_back_to_back();
        test_reset_mid_all();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
